// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and FSM state type for the rr_arb16 arbiter
//
// Purpose: default requester count, grant-index width and the two-state
// arbiter FSM encoding, imported by rr_arb16.
// Ports: none (package).
package rr_arb_pkg;

  localparam int NUM_REQ_DFLT = 16;
  localparam int ID_W         = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/lsb_prio_enc16.sv
// rtl/lsb_prio_enc16.sv - combinational 16-bit lowest-set-bit priority encoder
//
// Purpose: reports the index of the lowest set bit of vec.
// Ports:
//   vec  in  16  vector to search
//   idx  out 4   index of lowest set bit (0 when vec is zero)
//   any  out 1   vec has at least one bit set
module lsb_prio_enc16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        any
);

  always_comb begin
    idx = 4'd0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - 16-requester round-robin arbiter with registered grant outputs
//
// Purpose: grants one requester at a time, held until done, withdrawal of
// the request, or (macro RR_ARB_TIMEOUT_EN) MAX_HOLD cycles have elapsed.
// Ports:
//   clk      in  1   clock, rising edge
//   rst      in  1   asynchronous active-high reset
//   req      in  16  request vector, bit i = requester i
//   done     in  1   single-cycle release pulse
//   gnt      out 16  one-hot grant, registered
//   gnt_id   out 4   binary index of grantee, registered (0 when idle)
//   gnt_vld  out 1   a grant is held, registered
//   timeout  out 1   single-cycle forced-release pulse (constant 0 without
//                    RR_ARB_TIMEOUT_EN)
module rr_arb16
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DFLT,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               timeout
);

  if (NUM_REQ != 16) begin : g_bad_num_req
    $error("rr_arb16: only NUM_REQ=16 is supported");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb16: MAX_HOLD must be in 2..255");
  end

  arb_state_t         state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               vld_nxt;

  logic               expire;
  logic               release_ev;
  logic [ID_W-1:0]    search_base;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] masked_req;
  logic [ID_W-1:0]    m_idx, u_idx, win_id;
  logic               m_any, u_any;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_nxt;
  logic       to_nxt;
  // done in the expiry cycle wins: that is a normal release, not a timeout.
  assign expire = (state == BUSY) && (hold_cnt == HOLD_LAST) && !done;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign release_ev = (state == BUSY) && (done || !req[gnt_id] || expire);

  // On release the search restarts just above the outgoing grantee, which
  // is also the pointer value being committed this cycle.
  assign search_base = (state == BUSY) ? gnt_id + 4'd1 : ptr;

  always_comb begin
    arb_req = req;
    if (state == BUSY) arb_req[gnt_id] = 1'b0;
  end

  assign masked_req = arb_req & ({NUM_REQ{1'b1}} << search_base);

  lsb_prio_enc16 u_enc_masked (
    .vec (masked_req),
    .idx (m_idx),
    .any (m_any)
  );

  lsb_prio_enc16 u_enc_unmasked (
    .vec (arb_req),
    .idx (u_idx),
    .any (u_any)
  );

  // Nothing at or above the base means the search wraps to index 0.
  assign win_id = m_any ? m_idx : u_idx;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    vld_nxt   = gnt_vld;
`ifdef RR_ARB_TIMEOUT_EN
    to_nxt    = 1'b0;
    hold_nxt  = (state == BUSY) ? hold_cnt + 8'd1 : hold_cnt;
`endif
    if ((state == IDLE && u_any) || (release_ev && u_any)) begin
      state_nxt       = BUSY;
      gnt_nxt         = '0;
      gnt_nxt[win_id] = 1'b1;
      id_nxt          = win_id;
      vld_nxt         = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
      hold_nxt        = 8'd0;
`endif
    end else if (release_ev) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      id_nxt    = '0;
      vld_nxt   = 1'b0;
    end
    if (release_ev) begin
      ptr_nxt = gnt_id + 4'd1;
`ifdef RR_ARB_TIMEOUT_EN
      to_nxt  = expire;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_id  <= id_nxt;
      gnt_vld <= vld_nxt;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      timeout  <= to_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb16.sv
// tb/tb_rr_arb16.sv - self-checking bench for rr_arb16 (optional RR_ARB_TIMEOUT_EN build)
module tb_rr_arb16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_vld;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arb16 #(.NUM_REQ(16), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  id;
    logic        vld;
    logic [3:0]  ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rf, logic [15:0] r, logic d,
                              logic [15:0] g, logic [3:0] i, logic v, logic [3:0] p);
    vec_t e;
    e.rst_first = rf; e.req = r; e.done = d;
    e.gnt = g; e.id = i; e.vld = v; e.ptr = p;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 16'h0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 16'h0;
    done = 1'b0;

    // Group A: single requester grant and release.
    add(1, 16'h0001, 0, 16'h0001, 0, 1, 0);
    add(0, 16'h0001, 1, 16'h0000, 0, 0, 1);
    // Group B: all requesting, done every grant -> 1..15, 0, then withdraw.
    add(1, 16'hFFFF, 0, 16'h0001, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      logic [3:0] n;
      n = 4'(k + 1);
      add(0, 16'hFFFF, 1, 16'h0001 << n, n, 1, n);
    end
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    // Group C: pointer search above grantee, then wrap to 0.
    add(1, 16'h0108, 0, 16'h0008, 3, 1, 0);
    add(0, 16'h0108, 1, 16'h0100, 8, 1, 4);
    add(0, 16'h0008, 0, 16'h0008, 3, 1, 9);
    add(0, 16'h0009, 1, 16'h0001, 0, 1, 4);
    // Group D: withdrawal, done ignored in idle, stability against other reqs.
    add(1, 16'h0010, 0, 16'h0010, 4, 1, 0);
    add(0, 16'h0000, 0, 16'h0000, 0, 0, 5);
    add(0, 16'h0000, 1, 16'h0000, 0, 0, 5);
    add(0, 16'h0020, 1, 16'h0020, 5, 1, 5);
    add(0, 16'hFF20, 0, 16'h0020, 5, 1, 5);
    add(0, 16'hFF20, 1, 16'h0100, 8, 1, 6);

    do_reset();
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst gnt_id", 32'(gnt_id), 32'h0);
    chk("rst gnt_vld", 32'(gnt_vld), 32'h0);
    chk("rst timeout", 32'(timeout), 32'h0);
    chk("rst ptr", 32'(dut.ptr), 32'h0);

    for (int r = 0; r < tbl.size(); r++) begin
      if (tbl[r].rst_first) do_reset();
      req  = tbl[r].req;
      done = tbl[r].done;
      step();
      chk($sformatf("row%0d gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      chk($sformatf("row%0d gnt_id", r), 32'(gnt_id), 32'(tbl[r].id));
      chk($sformatf("row%0d gnt_vld", r), 32'(gnt_vld), 32'(tbl[r].vld));
      chk($sformatf("row%0d ptr", r), 32'(dut.ptr), 32'(tbl[r].ptr));
      chk($sformatf("row%0d timeout", r), 32'(timeout), 32'h0);
    end
    done = 1'b0;

    // Hold without done: timeout build forces release after 8 cycles.
    do_reset();
    req = 16'h0003;
    step();
    chk("hold first id", 32'(gnt_id), 32'h0);
    chk("hold first vld", 32'(gnt_vld), 32'h1);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("hold c%0d id", i), 32'(gnt_id), 32'h0);
      chk($sformatf("hold c%0d timeout", i), 32'(timeout), 32'h0);
    end
    step();
    chk("expire id", 32'(gnt_id), 32'h1);
    chk("expire gnt", 32'(gnt), 32'h0002);
    chk("expire timeout", 32'(timeout), 32'h1);
    chk("expire vld", 32'(gnt_vld), 32'h1);
    step();
    chk("post expire timeout", 32'(timeout), 32'h0);
    chk("post expire id", 32'(gnt_id), 32'h1);
`else
    for (int i = 1; i < 26; i++) begin
      step();
      chk($sformatf("hold c%0d id", i), 32'(gnt_id), 32'h0);
      chk($sformatf("hold c%0d vld", i), 32'(gnt_vld), 32'h1);
      chk($sformatf("hold c%0d timeout", i), 32'(timeout), 32'h0);
    end
`endif

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req = 16'h0020;
    step();
    chk("pre-rst id", 32'(gnt_id), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst gnt", 32'(gnt), 32'h0);
    chk("async rst vld", 32'(gnt_vld), 32'h0);
    chk("async rst id", 32'(gnt_id), 32'h0);
    chk("async rst timeout", 32'(timeout), 32'h0);
    chk("async rst ptr", 32'(dut.ptr), 32'h0);
    req = 16'h0021;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("after rst id", 32'(gnt_id), 32'h0);
    chk("after rst gnt", 32'(gnt), 32'h0001);
    chk("after rst vld", 32'(gnt_vld), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16, number of requesters; only 16 is supported.
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum grant length in cycles when the timeout feature is compiled in; legal range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port req, input, 16, request vector; bit i is requester i.
REQ-006 SHALL have port done, input, 1, single-cycle release pulse from the current grantee or the shared resource.
REQ-007 SHALL have port gnt, output, 16, one-hot grant vector, registered.
REQ-008 SHALL have port gnt_id, output, 4, binary index of the granted requester, registered.
REQ-009 SHALL have port gnt_vld, output, 1, high while any grant is held, registered.
REQ-010 SHALL have port timeout, output, 1, single-cycle pulse on forced release, registered.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 SHALL select winners round-robin from a 4-bit pointer ptr, searching upward from index ptr with wrap to 0; this means the lowest set bit of (req masked to bits >= ptr), or the lowest set bit of req if that masked vector is zero.
REQ-013 SHALL, in IDLE, move to BUSY when req is nonzero; gnt/gnt_id/gnt_vld appear exactly one cycle after req is sampled (1-cycle latency).
REQ-014 SHALL keep gnt and gnt_id stable in BUSY until a release event, regardless of changes on other req bits.
REQ-015 SHALL treat as a release event: done=1; or req[gnt_id]=0 (requester withdrew); or timeout expiry when the timeout feature is compiled in.
REQ-016 SHALL, on release in cycle t, set ptr to gnt_id+1 modulo 16, and arbitrate in cycle t over req with bit gnt_id cleared.
REQ-017 SHALL, on release with a nonzero arbitration result, present the new grant at t+1 with gnt_vld held high (back-to-back, no idle gap); otherwise it SHALL enter IDLE with gnt=0 and gnt_vld=0 at t+1.
REQ-018 SHALL ignore done while in IDLE.
REQ-019 SHALL guarantee gnt is zero or one-hot, gnt_vld equals |gnt, and gnt_id equals 0 whenever gnt_vld=0.
REQ-020 SHALL leave ptr unchanged while in IDLE and while in BUSY without a release event.

Reset
REQ-021 SHALL, while rst=1, force state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_vld=0, timeout=0, and the hold counter to 0, asynchronously.
REQ-022 SHALL discard an in-progress grant on reset mid-BUSY, with no done or timeout issued; arbitration resumes from ptr=0 on the first edge after rst falls.

Configuration
REQ-023 SHALL, with macro RR_ARB_TIMEOUT_EN defined, include an 8-bit hold counter. The counter clears when a grant is issued and increments each cycle in BUSY. When the counter reaches MAX_HOLD-1 and done=0 in the same cycle, the block SHALL force a release per REQ-016/017 and pulse timeout for one cycle.
REQ-024 SHALL, without RR_ARB_TIMEOUT_EN, omit the counter, tie timeout to constant 0, and hold a grant indefinitely until done or withdrawal.

Structure
REQ-025 SHALL place NUM_REQ default, ID width (4), and the FSM state enum (IDLE, BUSY) in shared package rr_arb_pkg.
REQ-026 SHALL use one sub-module, lsb_prio_enc16: combinational 16-bit lowest-set-bit encoder with outputs idx[3:0] and any; rr_arb16 SHALL instantiate two of these (masked search and unmasked search).

Verification
REQ-027 Bench SHALL cover: reset, then req=16'h0001 -> one cycle later gnt=16'h0001, gnt_id=0, gnt_vld=1; done pulse -> next cycle gnt=0, gnt_vld=0, ptr=1.
REQ-028 Bench SHALL cover: req=16'hFFFF held with done pulsed every grant -> gnt_id sequence 0,1,2,...,15,0 with gnt_vld never low.
REQ-029 Bench SHALL cover: grant on id 3 with req=16'h0108, done pulsed -> next grant id 8; with req=16'h0009 instead -> next grant id 0 (wrap).
REQ-030 Bench SHALL cover: req=16'h0010 granted id 4, then req=16'h0000 -> next cycle gnt_vld=0, with timeout=0.
REQ-031 Bench SHALL cover, with RR_ARB_TIMEOUT_EN and MAX_HOLD=8: req=16'h0003, no done -> id 0 held 8 cycles, timeout pulses once, next grant id 1; without the macro -> id 0 held for 20+ cycles and timeout stays 0.
REQ-032 Bench SHALL cover: rst asserted mid-BUSY (id 5) -> outputs zero immediately; with req=16'h0021 after release of rst -> grant id 0.
